// File: rtl/cache_mem_bridge_if.sv
// Bus bundles for cache_mem_bridge: controller-side line port and word-wide external memory port.
interface cache_ctrl_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LINE_WORDS = 4
);
    logic                         mem_cs;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [LINE_WORDS*WORD_W-1:0] wline;
    logic                         mem_ack;
    logic                         mem_err;
    logic [LINE_WORDS*WORD_W-1:0] rline;

    modport master (
        output mem_cs, mem_we, mem_addr, wline,
        input  mem_ack, mem_err, rline
    );

    modport slave (
        input  mem_cs, mem_we, mem_addr, wline,
        output mem_ack, mem_err, rline
    );
endinterface

interface ext_mem_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = 32
);
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [WORD_W-1:0] ext_wdata;
    logic [WORD_W-1:0] ext_rdata;
    logic              ext_ready;

    modport master (
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_ready
    );

    modport slave (
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_ready
    );
endinterface

// File: rtl/cache_mem_bridge.sv
// Line-transfer engine between the L1 cache controller and a word-wide memory bus.
// Define CACHE_BRIDGE_TIMEOUT_EN to add an 8-bit stall watchdog that aborts with mem_err.
module cache_mem_bridge #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input logic         clk,
    input logic         rst,
    cache_ctrl_if.slave ctrl,
    ext_mem_if.master   ext
);
    localparam int unsigned WORD_BYTES = WORD_W / 8;
    localparam int unsigned LINE_BYTES = LINE_WORDS * WORD_BYTES;
    localparam int unsigned IDX_W      = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                           state;
    state_t                           state_nxt;
    logic [ADDR_W-1:0]                base;
    logic                             dir;
    logic                             hold;
    logic                             last_we;
    logic [IDX_W-1:0]                 idx;
    logic [LINE_WORDS-1:0][WORD_W-1:0] wbuf;
    logic [LINE_WORDS-1:0][WORD_W-1:0] rbuf;
    logic                             start;
    logic                             beat;
    logic                             last_beat;
    logic                             timeout;

    // A held mem_cs after a completed line only restarts if the direction flips.
    assign start     = (state == IDLE) && ctrl.mem_cs && (!hold || (ctrl.mem_we != last_we));
    assign beat      = (state == XFER) && ext.ext_ready;
    assign last_beat = (idx == IDX_W'(LINE_WORDS - 1));

`ifdef CACHE_BRIDGE_TIMEOUT_EN
    logic [7:0] wdog;
    logic       err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state != XFER) || ext.ext_ready) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + 8'd1;
            end
            if (start) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    // The 255th consecutive stall cycle is the one that sees wdog == 254.
    assign timeout      = (state == XFER) && !ext.ext_ready && (wdog == 8'd254);
    assign ctrl.mem_err = (state == DONE) && err_q;
`else
    assign timeout      = 1'b0;
    assign ctrl.mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ext.ext_req  = 1'b0;
        ext.ext_we   = 1'b0;
        ctrl.mem_ack = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                ext.ext_req = 1'b1;
                ext.ext_we  = dir;
                if ((beat && last_beat) || timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ctrl.mem_ack = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base    <= '0;
            dir     <= 1'b0;
            hold    <= 1'b0;
            last_we <= 1'b0;
            idx     <= '0;
            wbuf    <= '0;
            rbuf    <= '0;
        end else begin
            if (start) begin
                base <= ctrl.mem_addr & ~ADDR_W'(LINE_BYTES - 1);
                dir  <= ctrl.mem_we;
                wbuf <= ctrl.wline;
                idx  <= '0;
            end
            if (beat) begin
                if (!dir) begin
                    rbuf[idx] <= ext.ext_rdata;
                end
                idx <= idx + IDX_W'(1);
            end
            // Dropping mem_cs always releases the hold, even in the DONE cycle.
            if (!ctrl.mem_cs) begin
                hold <= 1'b0;
            end else if (state == DONE) begin
                hold <= 1'b1;
            end
            if (state == DONE) begin
                last_we <= dir;
            end
        end
    end

    assign ext.ext_addr  = base + ADDR_W'(idx) * ADDR_W'(WORD_BYTES);
    assign ext.ext_wdata = wbuf[idx];
    assign ctrl.rline    = rbuf;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Self-checking bench for cache_mem_bridge: directed scenarios plus random line traffic against a memory model.
`timescale 1ns/1ps
module tb_cache_mem_bridge;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
    localparam int unsigned WORD_BYTES = WORD_W / 8;
    localparam int unsigned LINE_BYTES = LINE_WORDS * WORD_BYTES;

    typedef logic [LINE_W-1:0] val_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) ctrl_if ();
    ext_mem_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) ext_if ();

    cache_mem_bridge #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl_if),
        .ext  (ext_if)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [WORD_W-1:0] mem_model [logic [ADDR_W-1:0]];
    val_t exp_rline = '0;

    task automatic check(input string tag, input val_t obs, input val_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (!mem_model.exists(a)) mem_model[a] = WORD_W'($urandom);
        return mem_model[a];
    endfunction

    // mode: 0 always ready, 1 random stalls, 2 two stalls on beat 1, 3 never ready
    task automatic do_xfer(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                           input val_t line, input int unsigned mode, input logic keep_cs,
                           input logic exp_err);
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] waddr;
        logic [WORD_W-1:0] word;
        logic              rdy;
        int unsigned       beat_n = 0;
        int unsigned       stalls = 0;
        int unsigned       stall_run = 0;
        int unsigned       lat = 0;
        int unsigned       exp_lat;
        base = (addr / LINE_BYTES) * LINE_BYTES;
        ctrl_if.mem_cs   = 1'b1;
        ctrl_if.mem_we   = we;
        ctrl_if.mem_addr = addr;
        ctrl_if.wline    = line;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ctrl_if.mem_ack) begin
                lat = k;
                break;
            end
            if (ext_if.ext_req) begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    2:       rdy = !(beat_n == 1 && stall_run < 2);
                    default: rdy = 1'b0;
                endcase
                waddr = base + ADDR_W'(beat_n * WORD_BYTES);
                check({tag, " ext_addr"}, val_t'(ext_if.ext_addr), val_t'(waddr));
                check({tag, " ext_we"}, val_t'(ext_if.ext_we), val_t'(we));
                if (we) check({tag, " ext_wdata"}, val_t'(ext_if.ext_wdata),
                              val_t'(line[beat_n*WORD_W +: WORD_W]));
                if (rdy) begin
                    if (we) begin
                        mem_model[waddr] = line[beat_n*WORD_W +: WORD_W];
                        ext_if.ext_rdata = WORD_W'($urandom);
                    end else begin
                        word = mem_rd(waddr);
                        ext_if.ext_rdata = word;
                        exp_rline[beat_n*WORD_W +: WORD_W] = word;
                    end
                    beat_n++;
                    stall_run = 0;
                end else begin
                    ext_if.ext_rdata = WORD_W'($urandom);
                    stalls++;
                    stall_run++;
                end
                ext_if.ext_ready = rdy;
            end else begin
                ext_if.ext_ready = 1'($urandom_range(0, 1));
            end
        end
        exp_lat = exp_err ? 256 : LINE_WORDS + 1 + stalls;
        check({tag, " ack_latency"}, val_t'(lat), val_t'(exp_lat));
        check({tag, " mem_err"}, val_t'(ctrl_if.mem_err), val_t'(exp_err));
        check({tag, " beats"}, val_t'(beat_n), val_t'(exp_err ? 0 : LINE_WORDS));
        check({tag, " rline"}, ctrl_if.rline, exp_rline);
        if (!keep_cs) ctrl_if.mem_cs = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, " ack_one_cycle"}, val_t'(ctrl_if.mem_ack), val_t'(0));
        check({tag, " idle_req"}, val_t'(ext_if.ext_req), val_t'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        ctrl_if.mem_cs   = 1'b0;
        ctrl_if.mem_we   = 1'b0;
        ctrl_if.mem_addr = '0;
        ctrl_if.wline    = '0;
        ext_if.ext_ready = 1'b0;
        ext_if.ext_rdata = '0;
        repeat (3) @(negedge clk);

        check("rst mem_ack", val_t'(ctrl_if.mem_ack), val_t'(0));
        check("rst mem_err", val_t'(ctrl_if.mem_err), val_t'(0));
        check("rst ext_req", val_t'(ext_if.ext_req), val_t'(0));
        check("rst ext_we", val_t'(ext_if.ext_we), val_t'(0));
        check("rst ext_addr", val_t'(ext_if.ext_addr), val_t'(0));
        check("rst ext_wdata", val_t'(ext_if.ext_wdata), val_t'(0));
        check("rst rline", ctrl_if.rline, val_t'(0));
        rst = 1'b1;
        @(negedge clk);

        mem_model[32'h1230] = 32'hA0;
        mem_model[32'h1234] = 32'hA1;
        mem_model[32'h1238] = 32'hA2;
        mem_model[32'h123C] = 32'hA3;
        do_xfer("refill_1234", 1'b0, 32'h0000_1234, {4{32'hDEAD_BEEF}}, 0, 1'b0, 1'b0);
        check("refill_1234 words", ctrl_if.rline, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        do_xfer("wb_stall", 1'b1, 32'h0000_2004, {32'h44, 32'h33, 32'h22, 32'h11}, 2, 1'b0, 1'b0);
        check("wb_stall mem0", val_t'(mem_model[32'h2000]), val_t'(32'h11));
        check("wb_stall mem3", val_t'(mem_model[32'h200C]), val_t'(32'h44));

        // write-back then refill of the same line with mem_cs held high throughout
        do_xfer("b2b_wb", 1'b1, 32'h0000_2400, {32'h8, 32'h7, 32'h6, 32'h5}, 0, 1'b1, 1'b0);
        do_xfer("b2b_refill", 1'b0, 32'h0000_2400, '0, 0, 1'b1, 1'b0);
        check("b2b_refill words", ctrl_if.rline, {32'h8, 32'h7, 32'h6, 32'h5});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold no_req", val_t'(ext_if.ext_req), val_t'(0));
            check("hold no_ack", val_t'(ctrl_if.mem_ack), val_t'(0));
        end
        ctrl_if.mem_cs = 1'b0;
        @(negedge clk);

        // reset asserted during the third beat of a refill
        ctrl_if.mem_cs   = 1'b1;
        ctrl_if.mem_we   = 1'b0;
        ctrl_if.mem_addr = 32'h0000_3008;
        ext_if.ext_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            ext_if.ext_rdata = WORD_W'($urandom);
        end
        check("rst_mid pre_req", val_t'(ext_if.ext_req), val_t'(1));
        rst = 1'b0;
        #1;
        check("rst_mid ext_req", val_t'(ext_if.ext_req), val_t'(0));
        check("rst_mid mem_ack", val_t'(ctrl_if.mem_ack), val_t'(0));
        check("rst_mid rline", ctrl_if.rline, val_t'(0));
        exp_rline = '0;
        ctrl_if.mem_cs = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_mid no_ack", val_t'(ctrl_if.mem_ack), val_t'(0));
        end
        rst = 1'b1;
        @(negedge clk);
        do_xfer("after_rst", 1'b0, 32'h0000_3008, '0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 16; n++) begin
            logic              we;
            logic [ADDR_W-1:0] a;
            val_t              line;
            we   = 1'($urandom_range(0, 1));
            a    = ADDR_W'(32'h4000 + $urandom_range(0, 7) * LINE_BYTES + $urandom_range(0, LINE_BYTES - 1));
            line = {$urandom, $urandom, $urandom, $urandom};
            do_xfer(we ? "rand_wb" : "rand_refill", we, a, line, 1, 1'b0, 1'b0);
        end

`ifdef CACHE_BRIDGE_TIMEOUT_EN
        do_xfer("timeout", 1'b0, 32'h0000_5000, '0, 3, 1'b0, 1'b1);
        do_xfer("post_timeout", 1'b0, 32'h0000_5000, '0, 0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_mem_bridge.md
# cache_mem_bridge

Line-transfer engine between the L1 cache controller and the word-wide external memory bus. It accepts a cache-line request from the controller (`mem_cs`/`mem_we`), moves the line one word at a time over a req/ready handshake, and returns a single-cycle `mem_ack`. The controller's `ext_mem_ack` input is driven from this block's `mem_ack` output. Write-back moves a line from the cache SRAM to memory. Refill returns a line from memory to the cache SRAM.

## Interface
- `ADDR_W`, 32: byte address width.
- `WORD_W`, 32: external bus word width. Must be a multiple of 8.
- `LINE_WORDS`, 4: words per cache line. Must be a power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_cs` in 1: line request from the cache controller (level).
- `mem_we` in 1: 1 = write-back, 0 = refill.
- `mem_addr` in ADDR_W: line address. Offset bits are ignored.
- `wline` in LINE_WORDS*WORD_W: line to write back. Word 0 is in the LSBs.
- `mem_ack` out 1: one-cycle completion pulse to the controller.
- `mem_err` out 1: asserted with `mem_ack` when a transfer was aborted.
- `rline` out LINE_WORDS*WORD_W: refilled line. Word 0 is in the LSBs.
- `ext_req` out 1: external word request.
- `ext_we` out 1: external write enable.
- `ext_addr` out ADDR_W: word byte address.
- `ext_wdata` out WORD_W: write data.
- `ext_rdata` in WORD_W: read data. Valid in the cycle where `ext_ready`=1.
- `ext_ready` in 1: word accepted (write) or data valid (read).

## Operation
- States: IDLE, XFER, DONE.
- Reset values: state IDLE, and all outputs 0 (`mem_ack`, `mem_err`, `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `rline`). `hold` = 0, `last_we` = 0, `idx` = 0.
- Start condition, evaluated in IDLE: `mem_cs`=1 and (`hold`=0 or `mem_we`≠`last_we`).
- On start:
  - latch `base` = `mem_addr` with the low log2(LINE_WORDS*WORD_W/8) bits cleared;
  - latch `dir` = `mem_we`;
  - latch `wline` into an internal buffer;
  - set `idx`=0 and go to XFER.
- In XFER:
  - `ext_req`=1 and `ext_we`=`dir`;
  - `ext_addr` = `base` + `idx`*(WORD_W/8);
  - `ext_wdata` = buffer word `idx`.
- Beat completes when `ext_ready`=1 in XFER:
  - on a refill, `rline` word `idx` ← `ext_rdata`;
  - `idx`++, wrapping modulo LINE_WORDS;
  - if `idx` was LINE_WORDS-1, go to DONE.
- In DONE: `mem_ack`=1 for exactly one cycle. Then set `hold`=1 and `last_we`=`dir`, and go to IDLE.
- `hold` clears in any cycle where `mem_cs`=0.
  - This blocks a spurious re-start while the controller holds `mem_cs` high through COMPARE_TAG after a refill.
  - A write-back followed immediately by a refill with `mem_cs` held high starts correctly, because `mem_we` changed.
- `ext_ready` is ignored whenever `ext_req`=0.
- `mem_cs`/`mem_we`/`mem_addr` changes during XFER or DONE are ignored. Transfers are never cancelled by the controller.
- `rline` holds its value until the next refill overwrites it beat by beat. Write-backs never modify `rline`.
- Reset asserted mid-transfer: immediate return to IDLE. `ext_req` drops asynchronously, no ack is issued, and `rline` is cleared.

## Timing
- Request present in cycle C (IDLE): XFER begins in C+1.
- With `ext_ready` tied to 1: beats occur in C+1 … C+LINE_WORDS, `mem_ack` is high in C+LINE_WORDS+1, and IDLE resumes at C+LINE_WORDS+2.
- Each wait cycle (`ext_ready`=0) adds one cycle. `ext_addr`, `ext_we` and `ext_wdata` are stable while `ext_req`=1 and `ext_ready`=0.
- The controller sees the ack in its WRITE_BACK/ALLOCATE state. The earliest next start is the cycle after DONE.

## Configuration
- `CACHE_BRIDGE_TIMEOUT_EN` defined:
  - an 8-bit watchdog counts consecutive XFER cycles with `ext_ready`=0, and resets on each beat;
  - on reaching 255, go to DONE with `mem_err`=1 alongside `mem_ack`;
  - `rline` words not yet received keep their prior contents.
- Not defined: no watchdog, `mem_err` tied to 0, and XFER waits indefinitely.

## Test plan
- Refill, `mem_addr`=0x0000_1234, `ext_ready`=1:
  - `ext_addr` = 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles;
  - `ext_rdata` = 0xA0..0xA3 gives `rline` = {A3,A2,A1,A0};
  - `mem_ack` is high exactly at C+5.
- Write-back, `wline`={44,33,22,11}, `ext_ready` low for 2 cycles on beat 1:
  - writes 0x11, 0x22, 0x33, 0x44 in order;
  - `ext_wdata` stays at 0x22 during the stall;
  - `mem_ack` at C+7.
- Write-back, then `mem_we` 1→0 with `mem_cs` held high: refill starts the cycle after ack. After the refill ack, with `mem_cs` still high for 3 cycles, no new `ext_req` appears.
- Reset asserted in XFER at beat 2: `ext_req`=0 immediately, no `mem_ack`, `rline`=0, next request restarts at word 0.
- `CACHE_BRIDGE_TIMEOUT_EN`, `ext_ready` stuck at 0: `mem_ack` and `mem_err` pulse together after 255 stall cycles. The next request runs normally with `mem_err`=0.
